// File: rtl/uart_core_pkg.sv
// Shared register map, status bit positions and FSM encoding for the UART core.
package uart_core_pkg;

    localparam logic [1:0] UartRegTx   = 2'd0;
    localparam logic [1:0] UartRegStat = 2'd1;

    localparam int StatTxBusy  = 0;
    localparam int StatRxValid = 1;
    localparam int StatRxOvr   = 2;
    localparam int StatRxFerr  = 3;
    localparam int StatTxOvr   = 4;

    // 8N1: one start bit, eight data bits, one stop bit.
    localparam int UartFrameBits = 10;
    localparam int UartDataBits  = UartFrameBits - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Sticky flag update where a same-cycle set beats a write-1-to-clear.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/uart_core_if.sv
// Register bus between the per-CPU UART arbiter/mux (master) and the UART core (slave).
interface uart_core_if #(
    parameter int DATA_W = 8
);
    logic              uart_rd;
    logic              uart_wr;
    logic [1:0]        uart_addr;
    logic [DATA_W-1:0] uart_din;
    logic [DATA_W-1:0] uart_dout;

    modport master (
        output uart_rd, uart_wr, uart_addr, uart_din,
        input  uart_dout
    );

    modport slave (
        input  uart_rd, uart_wr, uart_addr, uart_din,
        output uart_dout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, pointers carry one extra bit to tell full from empty.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic              do_push;
    logic              do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        do_pop   = pop && !empty;
        // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
        dout     = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART peripheral: TX serializer, RX deserializer with FIFO, sticky status register.
module uart_core
    import uart_core_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int RX_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_core_if.slave     bus,
    input  logic           rxd,
    output logic           txd,
    output logic           irq
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UartDataBits);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UartDataBits - 1);

    uart_state_e       tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;

    uart_state_e       rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_sync_q, rx_sync_d;
    logic              rx_prev_q, rx_prev_d;

    logic              tx_ovr_q, tx_ovr_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              wr_tx, wr_stat, rd_rx;
    logic              tx_ovr_set, rx_ovr_set, rx_ferr_set;
    logic              rx_push;
    logic              fifo_pop, fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] status;

    uart_rx_fifo #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_shift_q),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        wr_tx    = bus.uart_wr && (bus.uart_addr == UartRegTx);
        wr_stat  = bus.uart_wr && (bus.uart_addr == UartRegStat);
        rd_rx    = bus.uart_rd && (bus.uart_addr == UartRegTx);
        fifo_pop = rd_rx && !fifo_empty;
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_ovr_set = wr_tx && (tx_state_q != ST_IDLE);
        unique case (tx_state_q)
            ST_IDLE: begin
                if (wr_tx) begin
                    tx_shift_d = bus.uart_din;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_meta_d   = rxd;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A line already back high at mid-start-bit was only a glitch.
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                    rx_bit_d   = rx_bit_q + BIT_W'(1);
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_push     = rx_sync_q;
                    rx_ferr_set = !rx_sync_q;
                    rx_state_d  = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ovr_set = rx_push && fifo_full && !fifo_pop;
        tx_ovr_d   = sticky_next(tx_ovr_q, tx_ovr_set, wr_stat && bus.uart_din[StatTxOvr]);
        rx_ovr_d   = sticky_next(rx_ovr_q, rx_ovr_set, wr_stat && bus.uart_din[StatRxOvr]);
        rx_ferr_d  = sticky_next(rx_ferr_q, rx_ferr_set, wr_stat && bus.uart_din[StatRxFerr]);
        irq_d      = !fifo_empty;

        status              = '0;
        status[StatTxBusy]  = (tx_state_q != ST_IDLE);
        status[StatRxValid] = !fifo_empty;
        status[StatRxOvr]   = rx_ovr_q;
        status[StatRxFerr]  = rx_ferr_q;
        status[StatTxOvr]   = tx_ovr_q;

        dout_d = dout_q;
        if (bus.uart_rd) begin
            unique case (bus.uart_addr)
                UartRegTx:   dout_d = fifo_empty ? '0 : fifo_dout;
                UartRegStat: dout_d = status;
                default:     dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            tx_ovr_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            irq_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            tx_ovr_q   <= tx_ovr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
            irq_q      <= irq_d;
            dout_q     <= dout_d;
        end
    end

    assign txd           = txd_q;
    assign irq           = irq_q;
    assign bus.uart_dout = dout_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: RX/TX scoreboards plus a small status-flag model.
module tb_uart_core;
    import uart_core_pkg::*;

    localparam int CPB   = 16;
    localparam int FRAME = UartFrameBits * CPB;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;
    logic irq;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic       mdl_rx_ovr;
    logic       mdl_rx_ferr;
    logic       mdl_tx_ovr;

    uart_core_if #(.DATA_W(8)) bus ();

    uart_core #(
        .DATA_W       (8),
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rxd (rxd),
        .txd (txd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mdl_status(input logic busy);
        return {3'b000, mdl_tx_ovr, mdl_rx_ferr, mdl_rx_ovr, logic'(rx_exp_q.size() != 0), busy};
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.uart_wr   = 1'b1;
        bus.uart_addr = a;
        bus.uart_din  = d;
        @(negedge clk);
        bus.uart_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.uart_rd   = 1'b1;
        bus.uart_addr = a;
        @(negedge clk);
        bus.uart_rd   = 1'b0;
        d             = bus.uart_dout;
    endtask

    task automatic tx_write(input logic [7:0] d, input bit accepted);
        if (accepted) tx_exp_q.push_back(d);
        else          mdl_tx_ovr = 1'b1;
        bus_write(UartRegTx, d);
    endtask

    task automatic stat_read(input string tag);
        logic [7:0] d;
        bus_read(UartRegStat, d);
        check(tag, d, mdl_status(1'b0));
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] d;
        logic [7:0] exp;
        exp = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'h00;
        bus_read(UartRegTx, d);
        check(tag, d, exp);
    endtask

    task automatic w1c(input logic [7:0] mask);
        if (mask[StatRxOvr])  mdl_rx_ovr  = 1'b0;
        if (mask[StatRxFerr]) mdl_rx_ferr = 1'b0;
        if (mask[StatTxOvr])  mdl_tx_ovr  = 1'b0;
        bus_write(UartRegStat, mask);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok, output bit irq_seen);
        if (!stop_ok)               mdl_rx_ferr = 1'b1;
        else if (rx_exp_q.size() < 4) rx_exp_q.push_back(b);
        else                        mdl_rx_ovr = 1'b1;
        irq_seen = 1'b0;
        for (int i = 0; i < UartFrameBits; i++) begin
            rxd = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : stop_ok;
            repeat (CPB) begin
                @(negedge clk);
                if (i == UartFrameBits - 1 && irq) irq_seen = 1'b1;
            end
        end
        rxd = 1'b1;
    endtask

    // Called on the negedge right after the accepting write edge.
    task automatic tx_monitor(input bit with_busy);
        logic [7:0] exp;
        logic [7:0] got_byte;
        int         sec;
        logic       exp_bit;
        got_byte = 8'h00;
        if (tx_exp_q.size() == 0) begin
            check("tx_sb_empty", 32'd0, 32'd1);
            return;
        end
        exp = tx_exp_q.pop_front();
        for (int k = 0; k < FRAME + 2; k++) begin
            sec     = k / CPB;
            exp_bit = (sec == 0) ? 1'b0 : (sec <= 8) ? exp[sec-1] : 1'b1;
            check($sformatf("txd_k%0d", k), txd, exp_bit);
            if (sec >= 1 && sec <= 8 && (k % CPB) == CPB / 2) got_byte[sec-1] = txd;
            if (with_busy && k >= 1) check($sformatf("tx_busy_k%0d", k), bus.uart_dout[StatTxBusy], k <= FRAME);
            if (with_busy && k == 0) begin
                bus.uart_rd   = 1'b1;
                bus.uart_addr = UartRegStat;
            end
            @(negedge clk);
        end
        bus.uart_rd = 1'b0;
        check("tx_byte", got_byte, exp);
    endtask

    initial begin
        bit         seen;
        logic [7:0] d;
        logic       all_high;

        rst           = 1'b1;
        rxd           = 1'b1;
        bus.uart_rd   = 1'b0;
        bus.uart_wr   = 1'b0;
        bus.uart_addr = 2'd0;
        bus.uart_din  = 8'h00;
        mdl_rx_ovr    = 1'b0;
        mdl_rx_ferr   = 1'b0;
        mdl_tx_ovr    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_dout", bus.uart_dout, 8'h00);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        stat_read("rst_status");

        tx_write(8'h55, 1'b1);
        tx_monitor(1'b1);

        send_rx(8'hA3, 1'b1, seen);
        check("irq_in_stop", seen, 1'b1);
        rx_read("rx_a3");
        @(negedge clk);
        check("irq_after_pop", irq, 1'b0);

        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, seen);
        stat_read("stat_ovr");
        for (int i = 0; i < 5; i++) rx_read($sformatf("rx_fill%0d", i));
        w1c(8'h04);
        stat_read("stat_ovr_clr");

        send_rx(8'h5A, 1'b0, seen);
        stat_read("stat_ferr");
        rx_read("rx_after_ferr");
        w1c(8'h08);
        stat_read("stat_ferr_clr");

        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        stat_read("stat_glitch");
        check("irq_glitch", irq, 1'b0);

        bus_write(2'd2, 8'hFF);
        bus_read(2'd2, d);
        check("addr2_read", d, 8'h00);

        tx_write(8'h11, 1'b1);
        fork
            tx_monitor(1'b0);
            begin
                repeat (20) @(negedge clk);
                tx_write(8'h22, 1'b0);
            end
        join
        all_high = 1'b1;
        repeat (40) begin
            all_high &= txd;
            @(negedge clk);
        end
        check("tx_idle_after_drop", all_high, 1'b1);
        stat_read("stat_tx_ovr");
        w1c(8'h10);
        stat_read("stat_tx_ovr_clr");

        send_rx(8'h7E, 1'b1, seen);
        bus_write(UartRegTx, 8'h00);
        repeat (5) @(negedge clk);
        check("pre_rst_txd", txd, 1'b0);
        check("pre_rst_irq", irq, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_exp_q.delete();
        check("mid_rst_txd", txd, 1'b1);
        @(negedge clk);
        check("mid_rst_irq", irq, 1'b0);
        stat_read("mid_rst_status");
        rx_read("mid_rst_rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Byte-oriented UART peripheral sitting directly downstream of the per-CPU UART arbiter/mux.
- Consumes its uart_rd / uart_wr / uart_addr / uart_din bus and returns uart_dout.
- Contains a TX serializer, an RX deserializer with a small receive FIFO, and a status register.
- Fixed 8N1 framing; baud rate set by parameter.

Parameters:
- DATA_W, 8, data bus width (matches UartDataWidth)
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 4
- RX_DEPTH, 4, RX FIFO entries, power of two

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_rd  in  1  read strobe, one cycle
- uart_wr  in  1  write strobe, one cycle
- uart_addr  in  2  register select
- uart_din  in  DATA_W  write data
- uart_dout  out  DATA_W  registered read data
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output
- irq  out  1  high while RX FIFO is non-empty

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: txd=1, uart_dout=0, irq=0. FIFO is empty; all sticky flags are 0; both FSMs are in IDLE.
- Register map:
  - addr 0 write: TX data.
  - addr 0 read: RX data, pops the FIFO.
  - addr 1 read: status = {0.., tx_ovr[4], rx_ferr[3], rx_ovr[2], rx_valid[1], tx_busy[0]}.
  - addr 1 write: write-1-to-clear for bits 4:2.
  - addr 2/3: reads return 0, writes ignored.
- Read latency: uart_dout is updated on the clk edge after the uart_rd cycle and holds until the next read.
- RX read when the FIFO is empty: returns 0, no pop.
- uart_rd and uart_wr asserted in the same cycle: both take effect.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state lasts CLKS_PER_BIT cycles; data is sent LSB first.
  - A write to addr 0 in IDLE latches uart_din. txd falls on the next edge and tx_busy=1 from that edge.
  - Frame is 10*CLKS_PER_BIT cycles. tx_busy clears on the edge that returns to IDLE; a back-to-back write is accepted that same cycle.
  - A write while busy is dropped and sets tx_ovr.
- RX sync: rxd passes through a 2-FF synchronizer. IDLE detects a 1->0 transition on the synchronized line.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat as a glitch and return to IDLE.
  - DATA: 8 samples, each CLKS_PER_BIT apart, shifted LSB first.
  - STOP: sample once. Low -> set rx_ferr and discard the byte. High -> push to the FIFO.
  - The FSM returns to IDLE immediately after the stop sample, so rx_valid can rise mid-stop-bit.
- FIFO: push when full -> byte dropped, rx_ovr set. Pop and push in the same cycle when full -> both succeed, count unchanged. Pointers wrap modulo RX_DEPTH; an extra count bit distinguishes full from empty.
- Flag precedence: a sticky set and a W1C clear of the same bit in the same cycle -> set wins.
- irq = rx_valid, registered.
- rst mid-frame: both FSMs are aborted, txd=1 on the next edge, and the FIFO is emptied.

Decomposition:
- define.v gains:
  - UartRegTx=2'd0, UartRegStat=2'd1
  - status bit indices
  - 8N1 frame length constant
- Sub-module uart_rx_fifo (parameterized DATA_W, RX_DEPTH). Ports: clk, rst, push, din, pop, dout, empty, full.
- TX/RX FSMs stay in uart_core.

Test Plan:
- Reset, then read addr 1 -> uart_dout=0x00; txd=1, irq=0.
- CLKS_PER_BIT=16; write 0x55 to addr 0 -> txd low for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high. Status bit0=1 throughout; bit0=0 at cycle 160.
- Drive rxd with frame 0xA3 -> irq rises during the stop bit. Read addr 0 -> 0xA3 one cycle later; irq=0 afterwards.
- Send 5 RX frames 0x01..0x05 without reading -> status=0x06. Four reads return 0x01..0x04, a fifth read returns 0x00. Write 0x04 to addr 1 -> rx_ovr clears.
- RX frame with low stop bit -> status bit3=1, FIFO stays empty. A 3-cycle low glitch on rxd -> no push, no flags.
- Write 0x11, then write 0x22 while busy -> only 0x11 is serialized; status bit4=1.
